// File: rtl/service_counter_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | service_pkg : shared window state encoding and field widths              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package service_pkg;
    localparam int NUM_W       = 4;
    localparam int TIME_W      = 4;
    localparam int NUM_WINDOWS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } win_state_t;
endpackage
`default_nettype wire

// File: rtl/service_counter_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | service_counter_bank_if : dispatcher load bus and window status returns  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface service_counter_bank_if #(
    parameter int SERVED_W = 8
);
    import service_pkg::*;

    logic                   ld1, ld2, ld3;
    logic [NUM_W-1:0]       dn1, dn2, dn3;
    logic [TIME_W-1:0]      dt1, dt2, dt3;
    logic [NUM_WINDOWS-1:0] busy;
    logic [NUM_W-1:0]       num1, num2, num3;
    logic [TIME_W-1:0]      rem1, rem2, rem3;
    logic [NUM_WINDOWS-1:0] done;
    logic [SERVED_W-1:0]    served1, served2, served3;
    logic [NUM_WINDOWS-1:0] ovr;
    logic                   tick;

    modport master (
        output ld1, ld2, ld3, dn1, dn2, dn3, dt1, dt2, dt3,
        input  busy, num1, num2, num3, rem1, rem2, rem3, done,
               served1, served2, served3, ovr, tick
    );

    modport slave (
        input  ld1, ld2, ld3, dn1, dn2, dn3, dt1, dt2, dt3,
        output busy, num1, num2, num3, rem1, rem2, rem3, done,
               served1, served2, served3, ovr, tick
    );
endinterface
`default_nettype wire

// File: rtl/service_counter_bank_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | service_window : one service counter (IDLE/SERVE/DONE) with statistics   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module service_window
    import service_pkg::*;
#(
    parameter int SERVED_W = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                tick,
    input  wire logic                ld,
    input  wire logic [NUM_W-1:0]    dn,
    input  wire logic [TIME_W-1:0]   dt,
    output logic                     busy,
    output logic                     done,
    output logic                     ovr,
    output logic [NUM_W-1:0]         num,
    output logic [TIME_W-1:0]        rem,
    output logic [SERVED_W-1:0]      served
);
    win_state_t          r_state,  w_state_nxt;
    logic [NUM_W-1:0]    r_num,    w_num_nxt;
    logic [TIME_W-1:0]   r_rem,    w_rem_nxt;
    logic [SERVED_W-1:0] r_served, w_served_nxt;
    logic                r_ovr,    w_ovr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_num    <= '0;
            r_rem    <= '0;
            r_served <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_num    <= w_num_nxt;
            r_rem    <= w_rem_nxt;
            r_served <= w_served_nxt;
            r_ovr    <= w_ovr_nxt;
        end
    end

    // A load only takes effect from IDLE, so a coincident tick never touches the new rem.
    always_comb begin
        w_state_nxt  = r_state;
        w_num_nxt    = r_num;
        w_rem_nxt    = r_rem;
        w_served_nxt = r_served;
        w_ovr_nxt    = r_ovr;
        case (r_state)
            IDLE: begin
                if (ld) begin
                    w_num_nxt   = dn;
                    w_rem_nxt   = dt;
                    w_state_nxt = (dt == '0) ? DONE : SERVE;
                end
            end
            SERVE: begin
                if (ld) w_ovr_nxt = 1'b1;
                if (tick) begin
                    if (r_rem == TIME_W'(1)) begin
                        w_rem_nxt   = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_rem_nxt   = r_rem - TIME_W'(1);
                    end
                end
            end
            DONE: begin
                if (ld) w_ovr_nxt = 1'b1;
                if (~&r_served) w_served_nxt = r_served + SERVED_W'(1);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The ld term closes the window the dispatcher would otherwise see on its capture edge.
    assign busy   = (r_state != IDLE) | ld;
    assign done   = (r_state == DONE);
    assign ovr    = r_ovr;
    assign num    = r_num;
    assign rem    = r_rem;
    assign served = r_served;
endmodule
`default_nettype wire

// File: rtl/service_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | service_counter_bank : tick prescaler plus three service windows         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module service_counter_bank
    import service_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int SERVED_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    service_counter_bank_if.slave bus
);
    localparam int c_CNT_W = 24;

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_tick;

    assign w_tick = (r_cnt == c_CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) r_cnt <= '0;
        else               r_cnt <= r_cnt + c_CNT_W'(1);
    end

    assign bus.tick = w_tick;

    service_window #(.SERVED_W(SERVED_W)) u_win1 (
        .clk(clk), .rst(rst), .tick(w_tick),
        .ld(bus.ld1), .dn(bus.dn1), .dt(bus.dt1),
        .busy(bus.busy[0]), .done(bus.done[0]), .ovr(bus.ovr[0]),
        .num(bus.num1), .rem(bus.rem1), .served(bus.served1)
    );

    service_window #(.SERVED_W(SERVED_W)) u_win2 (
        .clk(clk), .rst(rst), .tick(w_tick),
        .ld(bus.ld2), .dn(bus.dn2), .dt(bus.dt2),
        .busy(bus.busy[1]), .done(bus.done[1]), .ovr(bus.ovr[1]),
        .num(bus.num2), .rem(bus.rem2), .served(bus.served2)
    );

    service_window #(.SERVED_W(SERVED_W)) u_win3 (
        .clk(clk), .rst(rst), .tick(w_tick),
        .ld(bus.ld3), .dn(bus.dn3), .dt(bus.dt3),
        .busy(bus.busy[2]), .done(bus.done[2]), .ovr(bus.ovr[2]),
        .num(bus.num3), .rem(bus.rem3), .served(bus.served3)
    );
endmodule
`default_nettype wire

// File: tb/tb_service_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_service_counter_bank : directed stimulus with done-driven scoreboard  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_service_counter_bank;
    typedef struct {
        int         win;
        logic [3:0] num;
        int         served;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   model_served[3];
    int   pend[3];

    service_counter_bank_if #(.SERVED_W(8)) bus ();

    service_counter_bank #(.TICK_DIV(4), .SERVED_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_num(input int w);
        case (w)
            0: return 32'(bus.num1);
            1: return 32'(bus.num2);
            default: return 32'(bus.num3);
        endcase
    endfunction

    function automatic logic [31:0] get_rem(input int w);
        case (w)
            0: return 32'(bus.rem1);
            1: return 32'(bus.rem2);
            default: return 32'(bus.rem3);
        endcase
    endfunction

    function automatic logic [31:0] get_served(input int w);
        case (w)
            0: return 32'(bus.served1);
            1: return 32'(bus.served2);
            default: return 32'(bus.served3);
        endcase
    endfunction

    task automatic set_ld(input int w, input logic [3:0] n, input logic [3:0] t);
        case (w)
            0: begin bus.ld1 = 1'b1; bus.dn1 = n; bus.dt1 = t; end
            1: begin bus.ld2 = 1'b1; bus.dn2 = n; bus.dt2 = t; end
            default: begin bus.ld3 = 1'b1; bus.dn3 = n; bus.dt3 = t; end
        endcase
    endtask

    task automatic clr_ld();
        bus.ld1 = 1'b0; bus.ld2 = 1'b0; bus.ld3 = 1'b0;
    endtask

    // Record an accepted customer: its number and the served count expected after it.
    task automatic push(input int w, input logic [3:0] n);
        exp_t e;
        if (model_served[w] < 255) model_served[w]++;
        e.win = w; e.num = n; e.served = model_served[w];
        sb.push_back(e);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!bus.tick && n < 20) begin @(negedge clk); n++; end
        if (!bus.tick) chk("wait_tick_timeout", 0, 1);
    endtask

    task automatic wait_done(input int w);
        int n = 0;
        while (!bus.done[w] && n < 200) begin @(negedge clk); n++; end
        if (!bus.done[w]) chk("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_rem(input int w, input logic [3:0] r);
        int n = 0;
        while (get_rem(w) != 32'(r) && n < 100) begin @(negedge clk); n++; end
        chk("wait_rem", get_rem(w), 32'(r));
    endtask

    task automatic serve(input int w, input logic [3:0] n);
        set_ld(w, n, 4'd1);
        push(w, n);
        @(negedge clk);
        clr_ld();
        wait_done(w);
        @(negedge clk);
    endtask

    // Monitor: every done pulse pops the window's expected customer; served is checked a cycle later.
    always @(negedge clk) begin
        int idx;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i] >= 0) begin
                    chk($sformatf("sb_served%0d", i + 1), get_served(i), 32'(pend[i]));
                    pend[i] = -1;
                end
                if (bus.done[i]) begin
                    idx = -1;
                    foreach (sb[k]) if (idx < 0 && sb[k].win == i) idx = k;
                    if (idx < 0) begin
                        chk($sformatf("sb_unexpected_done%0d", i + 1), 1, 0);
                    end else begin
                        chk($sformatf("sb_num%0d", i + 1), get_num(i), 32'(sb[idx].num));
                        pend[i] = sb[idx].served;
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int ticks;
        for (int i = 0; i < 3; i++) begin model_served[i] = 0; pend[i] = -1; end
        clr_ld();
        bus.dn1 = '0; bus.dn2 = '0; bus.dn3 = '0;
        bus.dt1 = '0; bus.dt2 = '0; bus.dt3 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ovr", 32'(bus.ovr), 0);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_num1", get_num(0), 0);
        chk("rst_rem3", get_rem(2), 0);
        chk("rst_served2", get_served(1), 0);
        bus.ld2 = 1'b1;
        #1 chk("rst_busy_follows_ld", 32'(bus.busy), 32'b010);
        bus.ld2 = 1'b0;
        rst = 1'b0;

        // Basic service, load one cycle ahead of a tick.
        wait_tick();
        repeat (3) @(negedge clk);
        set_ld(0, 4'd5, 4'd3);
        push(0, 4'd5);
        #1 chk("t1_busy_in_ld", 32'(bus.busy[0]), 1);
        @(negedge clk);
        clr_ld();
        chk("t1_rem3", get_rem(0), 3);
        chk("t1_tick_next", 32'(bus.tick), 1);
        @(negedge clk);
        chk("t1_rem2", get_rem(0), 2);
        repeat (4) @(negedge clk);
        chk("t1_rem1", get_rem(0), 1);
        repeat (4) @(negedge clk);
        chk("t1_rem0", get_rem(0), 0);
        chk("t1_done", 32'(bus.done), 32'b001);
        @(negedge clk);
        chk("t1_busy_after", 32'(bus.busy[0]), 0);
        chk("t1_done_1clk", 32'(bus.done[0]), 0);
        chk("t1_served", get_served(0), 1);
        chk("t1_num_hold", get_num(0), 5);

        // Zero service time completes on the next cycle.
        set_ld(1, 4'd7, 4'd0);
        push(1, 4'd7);
        @(negedge clk);
        clr_ld();
        chk("t2_done", 32'(bus.done), 32'b010);
        chk("t2_rem", get_rem(1), 0);
        @(negedge clk);
        chk("t2_busy_after", 32'(bus.busy[1]), 0);
        chk("t2_served", get_served(1), 1);

        // Load coincident with tick: the load wins.
        wait_tick();
        set_ld(2, 4'd9, 4'd2);
        push(2, 4'd9);
        @(negedge clk);
        clr_ld();
        chk("t3_rem_not_decremented", get_rem(2), 2);
        ticks = 0;
        for (int n = 0; n < 50 && !bus.done[2]; n++) begin
            if (bus.tick) ticks++;
            @(negedge clk);
        end
        chk("t3_done_seen", 32'(bus.done[2]), 1);
        chk("t3_ticks_to_done", 32'(ticks), 2);
        @(negedge clk);

        // Overrun while serving.
        set_ld(0, 4'd4, 4'd3);
        push(0, 4'd4);
        @(negedge clk);
        clr_ld();
        wait_rem(0, 4'd2);
        set_ld(0, 4'd12, 4'd9);
        @(negedge clk);
        clr_ld();
        chk("t4_num_unchanged", get_num(0), 4);
        chk("t4_rem_unchanged", get_rem(0), 2);
        chk("t4_ovr_set", 32'(bus.ovr), 32'b001);
        wait_done(0);
        chk("t4_ovr_sticky", 32'(bus.ovr[0]), 1);
        @(negedge clk);

        // Parallel loads finish together.
        set_ld(0, 4'd1, 4'd1);
        set_ld(1, 4'd2, 4'd1);
        set_ld(2, 4'd3, 4'd1);
        push(0, 4'd1); push(1, 4'd2); push(2, 4'd3);
        @(negedge clk);
        clr_ld();
        for (int n = 0; n < 20 && bus.done == 3'b000; n++) @(negedge clk);
        chk("t5_done_all", 32'(bus.done), 32'b111);
        @(negedge clk);

        // Drive window 1 to saturation, then once more.
        while (model_served[0] < 255) serve(0, 4'(model_served[0]));
        chk("t5_served_255", get_served(0), 255);
        serve(0, 4'd14);
        chk("t5_served_sat", get_served(0), 255);

        // Reset in the middle of a service.
        set_ld(1, 4'd6, 4'd5);
        push(1, 4'd6);
        @(negedge clk);
        clr_ld();
        wait_rem(1, 4'd3);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin model_served[i] = 0; pend[i] = -1; end
        @(negedge clk);
        chk("t6_rem2", get_rem(1), 0);
        chk("t6_num2", get_num(1), 0);
        chk("t6_busy", 32'(bus.busy[1]), 0);
        chk("t6_done", 32'(bus.done), 0);
        chk("t6_served2", get_served(1), 0);
        chk("t6_served1", get_served(0), 0);
        chk("t6_ovr", 32'(bus.ovr), 0);
        chk("t6_tick", 32'(bus.tick), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_presc_c1", 32'(bus.tick), 0);
        @(negedge clk);
        chk("t6_presc_c2", 32'(bus.tick), 0);
        @(negedge clk);
        chk("t6_presc_c3", 32'(bus.tick), 1);
        chk("t6_no_done", 32'(bus.done), 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
